// File: rtl/im_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : im_fetch_ctrl_pkg
// Description : Shared constants for the P5 instruction-memory fetch control.
//               Holds the default reset PC, the default IM geometry and the
//               sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package im_fetch_ctrl_pkg;

  // Default first fetch byte address after load/restart
  localparam logic [31:0] c_reset_pc_dflt = 32'h0000_3000;
  // Default IM geometry (depth must be a power of two)
  localparam int          c_im_depth_dflt = 1024;
  localparam int          c_idx_w_dflt    = 10;

  // Sequencer state encoding
  localparam int                c_st_w    = 2;
  localparam logic [c_st_w-1:0] c_st_load = 2'd0;
  localparam logic [c_st_w-1:0] c_st_run  = 2'd1;
  localparam logic [c_st_w-1:0] c_st_halt = 2'd2;

endpackage : im_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/im_pc_range_chk.sv
`default_nettype none
// ============================================================================
// Module      : im_pc_range_chk
// Description : Combinational legality check of a candidate PC against the
//               IM window [RESET_PC, RESET_PC + IM_DEPTH*4). Also yields the
//               IM word index of the candidate.
// Ports       : i_pc       in  32     candidate byte address
//               o_illegal  out 1      misaligned or outside the IM window
//               o_idx      out IDX_W  word index = (i_pc-RESET_PC)>>2
// Revision    : 1.0 - initial release
// ============================================================================
module im_pc_range_chk
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc_dflt,
  parameter int          IM_DEPTH = c_im_depth_dflt,
  parameter int          IDX_W    = c_idx_w_dflt
) (
  input  logic [31:0]      i_pc,
  output logic             o_illegal,
  output logic [IDX_W-1:0] o_idx
);

  // Byte span of the IM window
  localparam logic [31:0] c_span = 32'(IM_DEPTH) << 2;

  logic [31:0] w_off;

  // Unsigned subtraction: anything below RESET_PC wraps to a huge offset
  // and therefore fails the span test as well.
  always_comb begin
    w_off     = i_pc - RESET_PC;
    o_illegal = (w_off[1:0] != 2'b00) || (w_off >= c_span);
    o_idx     = w_off[IDX_W+1:2];
  end

endmodule : im_pc_range_chk
`default_nettype wire

// File: rtl/im_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : im_fetch_ctrl
// Description : Instruction-memory sequencer for the P5 pipeline. Boot-loads
//               program words into IM over a valid/ready stream, then runs
//               the fetch PC (sequential / stall / redirect) and stops on
//               halt or on an illegal PC (sticky fault).
// Ports       : clk, reset (async, active low)
//               ld_valid/ld_data/ld_last/ld_ready  loader stream
//               im_we/im_waddr/im_wdata            IM write port
//               stall/redirect/redir_pc            F-stage PC control
//               halt_req/restart                   run control
//               pc/fetch_idx/f_valid/fault         fetch status
// Revision    : 1.0 - initial release
// ============================================================================
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc_dflt,
  parameter int          IM_DEPTH = c_im_depth_dflt,
  parameter int          IDX_W    = c_idx_w_dflt
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             im_we,
  output logic [IDX_W-1:0] im_waddr,
  output logic [31:0]      im_wdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redir_pc,
  input  logic             halt_req,
  input  logic             restart,
  output logic [31:0]      pc,
  output logic [IDX_W-1:0] fetch_idx,
  output logic             f_valid,
  output logic             fault
);

  localparam logic [IDX_W-1:0] c_idx_max = IDX_W'(IM_DEPTH - 1);
  localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

  logic [c_st_w-1:0] r_state;
  logic [c_st_w-1:0] w_state_nxt;
  logic              r_ld_en;      // holds ld_ready low for the first edge after reset
  logic [IDX_W-1:0]  r_ld_idx;
  logic [31:0]       r_pc;
  logic [IDX_W-1:0]  r_fetch_idx;
  logic              r_fault;

  logic [31:0]       w_pc_cand;
  logic              w_cand_illegal;
  logic [IDX_W-1:0]  w_cand_idx;
  logic              w_pc_take;
  logic              w_restart;
  logic              w_fault_set;

  im_pc_range_chk #(
    .RESET_PC (RESET_PC),
    .IM_DEPTH (IM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_range_chk (
    .i_pc      (w_pc_cand),
    .o_illegal (w_cand_illegal),
    .o_idx     (w_cand_idx)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_load;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and PC-update decision
  always_comb begin
    w_state_nxt = r_state;
    w_pc_cand   = redirect ? redir_pc : (r_pc + 32'd4);
    w_pc_take   = 1'b0;
    w_restart   = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      c_st_load: begin
        // Last word either flagged or forced by a full IM; no index wrap.
        if (im_we && (ld_last || (r_ld_idx == c_idx_max))) begin
          w_state_nxt = c_st_run;
        end
      end
      c_st_run: begin
        // halt > stall > redirect > sequential; a stalled redirect is dropped.
        if (halt_req) begin
          w_state_nxt = c_st_halt;
        end else if (!stall) begin
          if (w_cand_illegal) begin
            w_fault_set = 1'b1;
            w_state_nxt = c_st_halt;
          end else begin
            w_pc_take   = 1'b1;
          end
        end
      end
      c_st_halt: begin
        if (restart) begin
          w_restart   = 1'b1;
          w_state_nxt = c_st_run;
        end
      end
      default: begin
        w_state_nxt = c_st_load;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ld_ready = (r_state == c_st_load) && r_ld_en;
    im_we    = ld_ready && ld_valid;
    f_valid  = (r_state == c_st_run) && !r_fault;
  end

  assign im_waddr  = r_ld_idx;
  assign im_wdata  = ld_data;
  assign pc        = r_pc;
  assign fetch_idx = r_fetch_idx;
  assign fault     = r_fault;

  // Load enable and load index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_en  <= 1'b0;
      r_ld_idx <= '0;
    end else begin
      r_ld_en <= 1'b1;
      if (im_we) begin
        r_ld_idx <= r_ld_idx + c_idx_one;
      end
    end
  end

  // PC, fetch index and sticky fault
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_fetch_idx <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (w_restart) begin
        r_pc        <= RESET_PC;
        r_fetch_idx <= '0;
        r_fault     <= 1'b0;
      end else if (w_pc_take) begin
        r_pc        <= w_pc_cand;
        r_fetch_idx <= w_cand_idx;
      end else if (w_fault_set) begin
        r_fault     <= 1'b1;
      end
    end
  end

endmodule : im_fetch_ctrl
`default_nettype wire

// File: tb/tb_im_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_im_fetch_ctrl
// Description : Scoreboard bench for im_fetch_ctrl. A driver issues one
//               stimulus vector per cycle and pushes the expected outputs of
//               a behavioural model; a monitor pops and compares on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_fetch_ctrl;

  localparam logic [31:0] c_rpc   = 32'h0000_3000;
  localparam int          c_depth = 1024;
  localparam int          c_m_load = 0;
  localparam int          c_m_run  = 1;
  localparam int          c_m_halt = 2;

  logic        clk = 1'b0;
  logic        reset, ld_valid, ld_last, ld_ready, im_we;
  logic        stall, redirect, halt_req, restart, f_valid, fault;
  logic [31:0] ld_data, im_wdata, redir_pc, pc;
  logic [9:0]  im_waddr, fetch_idx;

  always #5 clk = ~clk;

  im_fetch_ctrl #(
    .RESET_PC (c_rpc),
    .IM_DEPTH (c_depth),
    .IDX_W    (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .im_we     (im_we),
    .im_waddr  (im_waddr),
    .im_wdata  (im_wdata),
    .stall     (stall),
    .redirect  (redirect),
    .redir_pc  (redir_pc),
    .halt_req  (halt_req),
    .restart   (restart),
    .pc        (pc),
    .fetch_idx (fetch_idx),
    .f_valid   (f_valid),
    .fault     (fault)
  );

  typedef struct packed { logic [9:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] pc; logic [9:0] idx; } fe_t;
  typedef struct packed {
    logic ld_ready; logic f_valid; logic fault; logic we;
    logic [31:0] pc; logic [9:0] idx;
  } st_t;

  wr_t wq[$];
  fe_t fq[$];
  st_t sq[$];
  wr_t mon_w;
  fe_t mon_f;
  st_t mon_s;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  int          m_mode;
  int          m_idx;
  bit          m_ld_en;
  bit          m_fault;
  logic [31:0] m_pc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive, record expectations, advance the model past the edge
  task automatic cycle(bit rst_v, bit lv, logic [31:0] ld, bit ll,
                       bit st, bit rd, logic [31:0] rp, bit hr, bit rs);
    logic [31:0] cand;
    logic [31:0] off;
    bit          hs;
    st_t         s;
    @(posedge clk);
    #1;
    reset = rst_v; ld_valid = lv; ld_data = ld; ld_last = ll;
    stall = st; redirect = rd; redir_pc = rp; halt_req = hr; restart = rs;
    if (!rst_v) begin
      m_mode = c_m_load; m_idx = 0; m_pc = c_rpc; m_fault = 0; m_ld_en = 0;
    end
    hs         = (m_mode == c_m_load) && m_ld_en && lv;
    off        = m_pc - c_rpc;
    s.ld_ready = (m_mode == c_m_load) && m_ld_en;
    s.f_valid  = (m_mode == c_m_run) && !m_fault;
    s.fault    = m_fault;
    s.we       = hs;
    s.pc       = m_pc;
    s.idx      = off[11:2];
    sq.push_back(s);
    if (hs) wq.push_back('{addr: m_idx[9:0], data: ld});
    if (s.f_valid) fq.push_back('{pc: m_pc, idx: s.idx});
    if (rst_v) begin
      case (m_mode)
        c_m_load: if (hs) begin
          if (ll || m_idx == c_depth - 1) m_mode = c_m_run;
          m_idx++;
        end
        c_m_run: begin
          if (hr) m_mode = c_m_halt;
          else if (!st) begin
            cand = rd ? rp : m_pc + 32'd4;
            off  = cand - c_rpc;
            if ((off % 4) != 0 || off >= 32'(c_depth * 4)) begin
              m_fault = 1; m_mode = c_m_halt;
            end else begin
              m_pc = cand;
            end
          end
        end
        default: if (rs) begin
          m_mode = c_m_run; m_pc = c_rpc; m_fault = 0;
        end
      endcase
      m_ld_en = 1;
    end
  endtask

  task automatic ld(bit lv, logic [31:0] d, bit ll);
    cycle(1'b1, lv, d, ll, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic run(bit st, bit rd, logic [31:0] rp, bit hr, bit rs);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, st, rd, rp, hr, rs);
  endtask

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)       return c_rpc + 32'(4 * $urandom_range(0, 1023));
    else if (k == 7) return c_rpc + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
    else if (k == 8) return c_rpc + 32'd4096 + 32'(4 * $urandom_range(0, 100));
    else             return c_rpc - 32'(4 * $urandom_range(1, 100));
  endfunction

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rand_target(),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        mon_s = sq.pop_front();
        chk("ctrl{ld_ready,f_valid,fault,im_we}", {60'd0, ld_ready, f_valid, fault, im_we},
            {60'd0, mon_s.ld_ready, mon_s.f_valid, mon_s.fault, mon_s.we});
        chk("pc", {32'd0, pc}, {32'd0, mon_s.pc});
        chk("fetch_idx", {54'd0, fetch_idx}, {54'd0, mon_s.idx});
      end
      if (im_we === 1'b1) begin
        if (wq.size() == 0) begin
          n_total++;
          $display("FAIL im_write: unexpected write addr %0d data %h, none expected", im_waddr, im_wdata);
        end else begin
          mon_w = wq.pop_front();
          chk("im_waddr", {54'd0, im_waddr}, {54'd0, mon_w.addr});
          chk("im_wdata", {32'd0, im_wdata}, {32'd0, mon_w.data});
        end
      end
      if (f_valid === 1'b1) begin
        if (fq.size() == 0) begin
          n_total++;
          $display("FAIL fetch: unexpected f_valid with pc %h, none expected", pc);
        end else begin
          mon_f = fq.pop_front();
          chk("fetch_pc", {32'd0, pc}, {32'd0, mon_f.pc});
          chk("fetch_pc_idx", {54'd0, fetch_idx}, {54'd0, mon_f.idx});
        end
      end
    end
  end

  // Driver
  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    stall = 1'b0; redirect = 1'b0; redir_pc = '0; halt_req = 1'b0; restart = 1'b0;
    m_mode = c_m_load; m_idx = 0; m_pc = c_rpc; m_fault = 0; m_ld_en = 0;

    repeat (3) cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Release; ld_ready stays low this cycle even with ld_valid high
    ld(1'b1, 32'h1111_1111, 1'b0);
    ld(1'b1, 32'hA000_0001, 1'b0);
    ld(1'b0, 32'h0, 1'b0);
    ld(1'b1, 32'hA000_0002, 1'b0);
    ld(1'b1, 32'hA000_0003, 1'b1);

    // Sequential fetch; control inputs in LOAD were ignored
    repeat (4) run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    // Stall with redirect pending: PC holds, redirect dropped
    repeat (2) run(1'b1, 1'b1, 32'h0000_3040, 1'b0, 1'b0);
    run(1'b0, 1'b1, 32'h0000_3040, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);  // restart in RUN ignored
    // Misaligned redirect -> fault
    run(1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0);
    repeat (2) run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    // Below window -> fault
    run(1'b0, 1'b1, 32'h0000_2FFC, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    // Last word then pc+4 -> fault, no wrap
    run(1'b0, 1'b1, 32'h0000_3FFC, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    // Halt beats stall and redirect
    run(1'b1, 1'b1, 32'h0000_3100, 1'b1, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    rand_run(400);

    // Reset during load word 5
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    ld(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) ld(1'b1, $urandom, 1'b0);
    cycle(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    ld(1'b1, 32'h6666_6666, 1'b0);
    // Stream 1025 words without ld_last: only 1024 are written
    for (int i = 0; i < 1025; i++) ld(1'b1, $urandom, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 32'h0000_3FFC, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Random load with gaps and random program length, then random run
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    begin
      int nw;
      int sent;
      nw = $urandom_range(5, 20);
      sent = 0;
      while (sent < nw) begin
        bit v;
        v = ($urandom_range(0, 2) != 0);
        ld(v, $urandom, v && (sent == nw - 1));
        if (v && sent > 0) sent++;
        else if (v && m_idx > 0) sent++;
      end
    end
    rand_run(400);

    @(negedge clk);
    #1;
    chk("status_queue_drained", 64'(sq.size()), 64'd0);
    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    chk("fetch_queue_drained", 64'(fq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_im_fetch_ctrl
`default_nettype wire
